tconv_fetch: RTL

Operand fetch responder for the transposed-convolution datapath. It answers the controller's `wgt_read` / `ifm_read` / `set_ifm` strobes and turns them into synchronous-SRAM reads at auto-incrementing addresses. It returns weight and IFM samples with fixed latency, substituting zeros for padding positions. It sits between the convolution controller and the weight/IFM memories, and reports completion and overrun.

---
 rtl/tconv_pkg.sv | 29 ++
 rtl/tconv_rd_pipe.sv | 35 +++
 rtl/tconv_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tconv_pkg.sv
// Shared definitions for the transposed-convolution operand fetch block:
// FSM encoding, default geometry and the derived sample/weight counts.
package tconv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int KERNEL_SIZE_DEF = 4;
  localparam int IFM_SIZE_DEF    = 9;
  localparam int PAD_DEF         = 2;
  localparam int CI_DEF          = 3;
  localparam int CO_DEF          = 4;

  // Width needed to hold values 0..count-1, never less than one bit.
  function automatic int ptr_width(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

  localparam int IFM_ACT   = IFM_SIZE_DEF - 2 * PAD_DEF;
  localparam int IFM_TOTAL = CI_DEF * IFM_ACT * IFM_ACT;
  localparam int WGT_TOTAL = CO_DEF * CI_DEF * KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
  localparam int IFM_PTR_W = ptr_width(IFM_TOTAL);
  localparam int WGT_PTR_W = ptr_width(WGT_TOTAL + 1);
  localparam int FILT_W    = ptr_width(CO_DEF + 1);

endpackage

// File: rtl/tconv_rd_pipe.sv
// Two-stage read pipe: stage 1 shadows the SRAM access, stage 2 registers the
// sample, substituting zero for slots tagged as padding or suppressed reads.
module tconv_rd_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  zero,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);

  logic s1_valid_reg;
  logic s1_zero_reg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_zero_reg  <= 1'b0;
      valid        <= 1'b0;
      data         <= '0;
    end else begin
      s1_valid_reg <= req;
      s1_zero_reg  <= zero;
      valid        <= s1_valid_reg;
      // SRAM data is only meaningful in the cycle after the access
      if (s1_valid_reg) begin
        data <= s1_zero_reg ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: rtl/tconv_fetch.sv
// Operand fetch responder: turns controller strobes into auto-incrementing SRAM
// reads and returns IFM / weight samples two cycles later with zero padding.
module tconv_fetch
  import tconv_pkg::*;
#(
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IFM_SIZE    = IFM_SIZE_DEF,
  parameter int PAD         = PAD_DEF,
  parameter int CI          = CI_DEF,
  parameter int CO          = CO_DEF,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int IFM_BASE    = 0,
  parameter int WGT_BASE    = 0
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  start_conv,
  input  logic                  end_conv,
  input  logic                  set_ifm,
  input  logic                  ifm_read,
  input  logic                  wgt_read,
  output logic                  ifm_mem_re,
  output logic [ADDR_WIDTH-1:0] ifm_mem_addr,
  input  logic [DATA_WIDTH-1:0] ifm_mem_rdata,
  output logic                  wgt_mem_re,
  output logic [ADDR_WIDTH-1:0] wgt_mem_addr,
  input  logic [DATA_WIDTH-1:0] wgt_mem_rdata,
  output logic [DATA_WIDTH-1:0] ifm_data,
  output logic                  ifm_valid,
  output logic [DATA_WIDTH-1:0] wgt_data,
  output logic                  wgt_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int ACT_SIDE = IFM_SIZE - 2 * PAD;
  localparam int IFM_CNT  = CI * ACT_SIDE * ACT_SIDE;
  localparam int WGT_CNT  = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
  localparam int IPTR_W   = ptr_width(IFM_CNT);
  localparam int WPTR_W   = ptr_width(WGT_CNT + 1);
  localparam int FCNT_W   = ptr_width(CO + 1);

  state_t state_reg, state_next;
  logic drain_reg, drain_next;
  logic done_reg, done_next;
  logic error_reg;
  logic [IPTR_W-1:0] ifm_ptr_reg;
  logic [WPTR_W-1:0] wgt_ptr_reg;
  logic [FCNT_W-1:0] filt_cnt_reg;

  logic run, accept, ifm_slot, ifm_exhausted;
  logic ifm_fetch, ifm_overrun, wgt_fetch, wgt_overrun;

  assign run           = (state_reg == ST_RUN);
  assign accept        = (state_reg == ST_IDLE) && start_conv;
  assign ifm_slot      = run && set_ifm;
  assign ifm_exhausted = (filt_cnt_reg == FCNT_W'(CO));
  assign ifm_fetch     = ifm_slot && ifm_read && !ifm_exhausted;
  assign ifm_overrun   = ifm_slot && ifm_read && ifm_exhausted;
  assign wgt_fetch     = run && wgt_read && (wgt_ptr_reg != WPTR_W'(WGT_CNT));
  assign wgt_overrun   = run && wgt_read && (wgt_ptr_reg == WPTR_W'(WGT_CNT));

  // Addresses are driven combinationally so the SRAM samples them in the strobe cycle.
  assign ifm_mem_re   = ifm_fetch;
  assign ifm_mem_addr = ifm_fetch ? ADDR_WIDTH'(IFM_BASE) + ADDR_WIDTH'(ifm_ptr_reg) : '0;
  assign wgt_mem_re   = wgt_fetch;
  assign wgt_mem_addr = wgt_fetch ? ADDR_WIDTH'(WGT_BASE) + ADDR_WIDTH'(wgt_ptr_reg) : '0;

  assign busy  = (state_reg != ST_IDLE);
  assign done  = done_reg;
  assign error = error_reg;

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_conv) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (end_conv) begin
          state_next = ST_DRAIN;
          drain_next = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_reg) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          drain_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      drain_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ifm_ptr_reg  <= '0;
      wgt_ptr_reg  <= '0;
      filt_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else if (accept) begin
      ifm_ptr_reg  <= '0;
      wgt_ptr_reg  <= '0;
      filt_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      // Each filter re-reads every active IFM channel, so the pointer wraps per filter
      if (ifm_fetch) begin
        if (ifm_ptr_reg == IPTR_W'(IFM_CNT - 1)) begin
          ifm_ptr_reg  <= '0;
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end else begin
          ifm_ptr_reg <= ifm_ptr_reg + 1'b1;
        end
      end
      if (wgt_fetch) wgt_ptr_reg <= wgt_ptr_reg + 1'b1;
      if (ifm_overrun || wgt_overrun) error_reg <= 1'b1;
    end
  end

  tconv_rd_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_ifm_pipe (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .req       (ifm_slot),
    .zero      (!ifm_fetch),
    .mem_rdata (ifm_mem_rdata),
    .data      (ifm_data),
    .valid     (ifm_valid)
  );

  tconv_rd_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_wgt_pipe (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .req       (wgt_fetch),
    .zero      (1'b0),
    .mem_rdata (wgt_mem_rdata),
    .data      (wgt_data),
    .valid     (wgt_valid)
  );

endmodule
